// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - state encoding and stage-index constants for the frame sequencer
package frame_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_JSTK = 3'd1,
    ST_COL  = 3'd2,
    ST_MOVE = 3'd3,
    ST_DRAW = 3'd4
  } state_t;

  localparam int NUM_STAGES = 4;

  localparam logic [1:0] IDX_JSTK = 2'd0;
  localparam logic [1:0] IDX_COL  = 2'd1;
  localparam logic [1:0] IDX_MOVE = 2'd2;
  localparam logic [1:0] IDX_DRAW = 2'd3;

  // Stage states are numbered 1..4, so a stage's index is its code minus one.
  function automatic logic [1:0] stage_idx(input state_t s);
    return 2'(s - 3'd1);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage cycle counter that flags a stage that never finished
module stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/frame_update_sequencer.sv
// rtl/frame_update_sequencer.sv - orders joystick, collision, move and draw once per frame tick
module frame_update_sequencer
  import frame_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 16
) (
  input  logic             Clk_100MHz,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             VMA_busy,
  input  logic             Clear_Flags,
  output logic             Jstk_Start,
  output logic             Col_Start,
  output logic             Move_Start,
  output logic             Draw_Start,
  input  logic             Jstk_Done,
  input  logic             Col_Done,
  input  logic             Move_Done,
  input  logic             Draw_Done,
  output logic             Busy,
  output logic [2:0]       Stage,
  output logic [CNT_W-1:0] Frame_Count,
  output logic             Overrun,
  output logic             Timeout
);

  state_t                  state, state_next;
  logic                    vma_q;
  logic                    tick;
  logic [NUM_STAGES-1:0]   done_v;
  logic [NUM_STAGES-1:0]   start_q, start_next;
  logic                    cur_done;
  logic                    expire;
  logic                    busy_q;
  logic [CNT_W-1:0]        frame_q;
  logic                    overrun_q, timeout_q;
  logic                    overrun_set, timeout_set, frame_inc;

  assign tick   = vma_q & ~VMA_busy;
  assign done_v = {Draw_Done, Move_Done, Col_Done, Jstk_Done};

  // A Done on the Start cycle itself belongs to a previous request and is ignored.
  assign cur_done = (state != ST_IDLE) && done_v[stage_idx(state)] && !start_q[stage_idx(state)];

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (Clk_100MHz),
    .rst_n  (Reset_n),
    .clear  (|start_next),
    .enable (state != ST_IDLE),
    .expire (expire)
  );

  always_comb begin
    state_next  = state;
    start_next  = '0;
    overrun_set = 1'b0;
    timeout_set = 1'b0;
    frame_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && Run) begin
          state_next           = ST_JSTK;
          start_next[IDX_JSTK] = 1'b1;
        end
      end
      ST_JSTK, ST_COL, ST_MOVE, ST_DRAW: begin
        overrun_set = tick;
        if (cur_done) begin
          if (state == ST_DRAW) begin
            state_next = ST_IDLE;
            frame_inc  = 1'b1;
          end else begin
            state_next                   = state_t'(state + 3'd1);
            start_next[stage_idx(state) + 2'd1] = 1'b1;
          end
        end else if (expire) begin
          state_next  = ST_IDLE;
          timeout_set = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      vma_q     <= 1'b0;
      start_q   <= '0;
      busy_q    <= 1'b0;
      frame_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state   <= state_next;
      vma_q   <= VMA_busy;
      start_q <= start_next;
      busy_q  <= (state_next != ST_IDLE);
      if (frame_inc) frame_q <= frame_q + CNT_W'(1);
      // Set has priority over a coincident clear.
      if (overrun_set)      overrun_q <= 1'b1;
      else if (Clear_Flags) overrun_q <= 1'b0;
      if (timeout_set)      timeout_q <= 1'b1;
      else if (Clear_Flags) timeout_q <= 1'b0;
    end
  end

  assign Jstk_Start  = start_q[IDX_JSTK];
  assign Col_Start   = start_q[IDX_COL];
  assign Move_Start  = start_q[IDX_MOVE];
  assign Draw_Start  = start_q[IDX_DRAW];
  assign Busy        = busy_q;
  assign Stage       = state;
  assign Frame_Count = frame_q;
  assign Overrun     = overrun_q;
  assign Timeout     = timeout_q;

endmodule
